// File: rtl/control_unit_pkg.sv
// Shared CPU definitions: opcodes, control-word bit positions and micro-step numbers.
// The ALU, register and RAM blocks import the same package.
package cpu_defs;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam int CW_HLT = 15;
   localparam int CW_MI  = 14;
   localparam int CW_RI  = 13;
   localparam int CW_RO  = 12;
   localparam int CW_IO  = 11;
   localparam int CW_II  = 10;
   localparam int CW_AI  = 9;
   localparam int CW_AO  = 8;
   localparam int CW_EO  = 7;
   localparam int CW_SU  = 6;
   localparam int CW_BI  = 5;
   localparam int CW_OI  = 4;
   localparam int CW_CE  = 3;
   localparam int CW_CO  = 2;
   localparam int CW_J   = 1;
   localparam int CW_FI  = 0;

   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T1 = 3'd1;
   localparam logic [2:0] T2 = 3'd2;
   localparam logic [2:0] T3 = 3'd3;
   localparam logic [2:0] T4 = 3'd4;

   typedef logic [15:0] ctrl_word_t;

   // Final micro-step of each instruction; unused opcodes end after fetch like NOP.
   function automatic logic [2:0] last_step(input logic [3:0] op);
      logic [2:0] ls;
      case (op)
         OP_ADD, OP_SUB: ls = T4;
         OP_LDA, OP_STA: ls = T3;
         OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: ls = T2;
         default: ls = T1;
      endcase
      return ls;
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Sequencer-side bundle: instruction/ALU-flag inputs and the control word and status it drives.
interface control_unit_if;

   logic [3:0]  opcode;
   logic        zf;
   logic        cf;
   logic [15:0] ctrl;
   logic        flag_z;
   logic        flag_c;
   logic [2:0]  step;

   modport master (
      output opcode, zf, cf,
      input  ctrl, flag_z, flag_c, step
   );

   modport slave (
      input  opcode, zf, cf,
      output ctrl, flag_z, flag_c, step
   );

endinterface

// File: rtl/control_unit_flags_register.sv
// Two-bit zero/carry flags register with load enable and synchronous reset.
module flags_register (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic zf,
   input  logic cf,
   output logic flag_z,
   output logic flag_c
);

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_z <= 1'b0;
         flag_c <= 1'b0;
      end else if (load) begin
         flag_z <= zf;
         flag_c <= cf;
      end
   end

endmodule

// File: rtl/control_unit.sv
// Microcoded sequencer for the 8-bit bus CPU: step counter, halt latch and
// combinational decode of {opcode, step} into the 16-bit control word.
module control_unit
   import cpu_defs::*;
#(
   parameter int STEPS = 5
) (
   input  logic           clk,
   input  logic           rst,
   control_unit_if.slave  bus
);

   localparam logic [2:0] STEP_MAX = 3'(STEPS - 1);

   logic [2:0] step_q;
   logic       halted;
   logic [2:0] last;
   logic       flag_z;
   logic       flag_c;
   ctrl_word_t cw;

   assign last = last_step(bus.opcode);

   // The >= guard keeps the counter in range if opcode changes mid-instruction.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         step_q <= T0;
         halted <= 1'b0;
      end else if (halted) begin
         step_q <= T0;
      end else if (step_q >= last || step_q >= STEP_MAX) begin
         step_q <= T0;
         if (bus.opcode == OP_HLT && step_q == T2)
            halted <= 1'b1;
      end else begin
         step_q <= step_q + 3'd1;
      end
   end

   always_comb begin
      // NOTE: default the whole word first so no path leaves a bit unassigned (no latch).
      cw = '0;
      if (halted) begin
         cw[CW_HLT] = 1'b1;
      end else begin
         // T0/T1 fetch ignores the opcode, which still holds the previous instruction.
         casez ({bus.opcode, step_q})
            {4'b????, T0}: begin
               cw[CW_CO] = 1'b1;
               cw[CW_MI] = 1'b1;
            end
            {4'b????, T1}: begin
               cw[CW_RO] = 1'b1;
               cw[CW_II] = 1'b1;
               cw[CW_CE] = 1'b1;
            end
            {OP_LDA, T2}, {OP_ADD, T2}, {OP_SUB, T2}, {OP_STA, T2}: begin
               cw[CW_IO] = 1'b1;
               cw[CW_MI] = 1'b1;
            end
            {OP_LDA, T3}: begin
               cw[CW_RO] = 1'b1;
               cw[CW_AI] = 1'b1;
            end
            {OP_ADD, T3}, {OP_SUB, T3}: begin
               cw[CW_RO] = 1'b1;
               cw[CW_BI] = 1'b1;
            end
            {OP_ADD, T4}: begin
               cw[CW_EO] = 1'b1;
               cw[CW_AI] = 1'b1;
               cw[CW_FI] = 1'b1;
            end
            {OP_SUB, T4}: begin
               cw[CW_EO] = 1'b1;
               cw[CW_AI] = 1'b1;
               cw[CW_SU] = 1'b1;
               cw[CW_FI] = 1'b1;
            end
            {OP_STA, T3}: begin
               cw[CW_AO] = 1'b1;
               cw[CW_RI] = 1'b1;
            end
            {OP_LDI, T2}: begin
               cw[CW_IO] = 1'b1;
               cw[CW_AI] = 1'b1;
            end
            {OP_JMP, T2}: begin
               cw[CW_IO] = 1'b1;
               cw[CW_J]  = 1'b1;
            end
            {OP_JC, T2}: begin
               cw[CW_IO] = flag_c;
               cw[CW_J]  = flag_c;
            end
            {OP_JZ, T2}: begin
               cw[CW_IO] = flag_z;
               cw[CW_J]  = flag_z;
            end
            {OP_OUT, T2}: begin
               cw[CW_AO] = 1'b1;
               cw[CW_OI] = 1'b1;
            end
            {OP_HLT, T2}: begin
               cw[CW_HLT] = 1'b1;
            end
            default: ;
         endcase
      end
   end

   flags_register u_flags (
      .clk    (clk),
      .rst    (rst),
      .load   (cw[CW_FI]),
      .zf     (bus.zf),
      .cf     (bus.cf),
      .flag_z (flag_z),
      .flag_c (flag_c)
   );

   assign bus.ctrl   = cw;
   assign bus.step   = step_q;
   assign bus.flag_z = flag_z;
   assign bus.flag_c = flag_c;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios followed by a random
// instruction stream compared against an instruction-level model.
module tb_control_unit;

   localparam logic [15:0] W_HLT = 16'h8000;
   localparam logic [15:0] W_MI  = 16'h4000;
   localparam logic [15:0] W_RI  = 16'h2000;
   localparam logic [15:0] W_RO  = 16'h1000;
   localparam logic [15:0] W_IO  = 16'h0800;
   localparam logic [15:0] W_II  = 16'h0400;
   localparam logic [15:0] W_AI  = 16'h0200;
   localparam logic [15:0] W_AO  = 16'h0100;
   localparam logic [15:0] W_EO  = 16'h0080;
   localparam logic [15:0] W_SU  = 16'h0040;
   localparam logic [15:0] W_BI  = 16'h0020;
   localparam logic [15:0] W_OI  = 16'h0010;
   localparam logic [15:0] W_CE  = 16'h0008;
   localparam logic [15:0] W_CO  = 16'h0004;
   localparam logic [15:0] W_J   = 16'h0002;
   localparam logic [15:0] W_FI  = 16'h0001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   logic        mz = 1'b0;
   logic        mc = 1'b0;
   logic [15:0] exp_q[$];

   control_unit_if bus ();

   control_unit #(.STEPS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Whole-instruction control-word sequence, one entry per clock.
   function automatic void build(input logic [3:0] op, input logic fz, input logic fc);
      exp_q = {W_CO | W_MI, W_RO | W_II | W_CE};
      case (op)
         4'h1: begin exp_q.push_back(W_IO | W_MI); exp_q.push_back(W_RO | W_AI); end
         4'h2: begin
            exp_q.push_back(W_IO | W_MI); exp_q.push_back(W_RO | W_BI);
            exp_q.push_back(W_EO | W_AI | W_FI);
         end
         4'h3: begin
            exp_q.push_back(W_IO | W_MI); exp_q.push_back(W_RO | W_BI);
            exp_q.push_back(W_EO | W_AI | W_SU | W_FI);
         end
         4'h4: begin exp_q.push_back(W_IO | W_MI); exp_q.push_back(W_AO | W_RI); end
         4'h5: exp_q.push_back(W_IO | W_AI);
         4'h6: exp_q.push_back(W_IO | W_J);
         4'h7: exp_q.push_back(fc ? (W_IO | W_J) : 16'h0000);
         4'h8: exp_q.push_back(fz ? (W_IO | W_J) : 16'h0000);
         4'hE: exp_q.push_back(W_AO | W_OI);
         4'hF: exp_q.push_back(W_HLT);
         default: ;
      endcase
   endfunction

   task automatic run_instr(input logic [3:0] op, input bit force_en, input logic fz, input logic fc);
      logic nz, nc;
      bit   upd;
      upd = 1'b0;
      nz  = 1'b0;
      nc  = 1'b0;
      build(op, mz, mc);
      for (int i = 0; i < exp_q.size(); i++) begin
         bus.opcode = (i == 0) ? 4'($urandom) : op;
         if (force_en) begin
            bus.zf = fz;
            bus.cf = fc;
         end else begin
            bus.zf = 1'($urandom);
            bus.cf = 1'($urandom);
         end
         #1;
         check($sformatf("op%h_step%0d", op, i), 16'(bus.step), 16'(i));
         check($sformatf("op%h_ctrl%0d", op, i), bus.ctrl, exp_q[i]);
         check($sformatf("op%h_fz%0d", op, i), 16'(bus.flag_z), 16'(mz));
         check($sformatf("op%h_fc%0d", op, i), 16'(bus.flag_c), 16'(mc));
         if ((op == 4'h2 || op == 4'h3) && i == 4) begin
            upd = 1'b1;
            nz  = bus.zf;
            nc  = bus.cf;
         end
         tick();
      end
      if (upd) begin
         mz = nz;
         mc = nc;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.opcode = 4'($urandom);
      tick();
      rst = 1'b0;
      mz = 1'b0;
      mc = 1'b0;
   endtask

   task automatic check_halted(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         bus.opcode = 4'($urandom);
         bus.zf = k[0];
         bus.cf = 1'($urandom);
         #1;
         check("halt_ctrl", bus.ctrl, 16'h8000);
         check("halt_step", 16'(bus.step), 16'd0);
         check("halt_fz", 16'(bus.flag_z), 16'(mz));
         check("halt_fc", 16'(bus.flag_c), 16'(mc));
         tick();
      end
   endtask

   initial begin
      logic [3:0] op;
      bus.opcode = 4'h0;
      bus.zf = 1'b0;
      bus.cf = 1'b0;

      tick();
      rst = 1'b0;
      #1;
      check("rst_step", 16'(bus.step), 16'd0);
      check("rst_ctrl", bus.ctrl, 16'h4004);
      check("rst_fz", 16'(bus.flag_z), 16'd0);
      check("rst_fc", 16'(bus.flag_c), 16'd0);

      run_instr(4'h0, 1'b0, 1'b0, 1'b0);
      run_instr(4'h0, 1'b0, 1'b0, 1'b0);

      run_instr(4'h3, 1'b1, 1'b1, 1'b0);
      #1;
      check("sub_fz", 16'(bus.flag_z), 16'd1);
      check("sub_fc", 16'(bus.flag_c), 16'd0);
      check("sub_step", 16'(bus.step), 16'd0);

      run_instr(4'h7, 1'b0, 1'b0, 1'b0);
      run_instr(4'h2, 1'b1, 1'b0, 1'b1);
      run_instr(4'h7, 1'b0, 1'b0, 1'b0);
      run_instr(4'h8, 1'b0, 1'b0, 1'b0);

      run_instr(4'hF, 1'b0, 1'b0, 1'b0);
      check_halted(10);
      do_reset();
      #1;
      check("post_halt_ctrl", bus.ctrl, 16'h4004);
      check("post_halt_step", 16'(bus.step), 16'd0);

      // ADD abandoned by reset at T3; zf held high afterwards must not reach the flags.
      run_instr(4'h2, 1'b1, 1'b1, 1'b1);
      bus.opcode = 4'h2;
      bus.zf = 1'b0;
      bus.cf = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("abort_pre_step", 16'(bus.step), 16'd3);
      rst = 1'b1;
      bus.zf = 1'b1;
      bus.cf = 1'b1;
      tick();
      rst = 1'b0;
      mz = 1'b0;
      mc = 1'b0;
      #1;
      check("abort_step", 16'(bus.step), 16'd0);
      check("abort_fz", 16'(bus.flag_z), 16'd0);
      check("abort_fc", 16'(bus.flag_c), 16'd0);
      tick();
      check("abort_step1", 16'(bus.step), 16'd1);
      check("abort_fz1", 16'(bus.flag_z), 16'd0);
      do_reset();

      run_instr(4'hB, 1'b0, 1'b0, 1'b0);
      run_instr(4'h1, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 300; n++) begin
         op = 4'($urandom_range(0, 14));
         if ($urandom_range(0, 19) == 0) op = 4'hF;
         run_instr(op, 1'b0, 1'b0, 1'b0);
         if (op == 4'hF) begin
            check_halted(3);
            do_reset();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
